// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - polarity, synchroniser, shared-tick debouncer and press/release events for front-panel buttons
//
// Ports:
//   clk             system clock (32768 Hz)
//   rst_n           synchronous active-low reset
//   btn_raw         raw button pins, NBTN bits
//   btn_active_high 1: pressed = pin high, 0: pressed = pin low
//   tick            one-cycle pulse every 2^PRESCALE_W clocks
//   held            debounced pressed level per button
//   press_pulse     one-cycle pulse in the first cycle held[i] is 1
//   release_pulse   one-cycle pulse in the first cycle held[i] is 0 after being 1
//   any_held        OR of held
//   first_idx       index of lowest-numbered held button, 0 when none held
//   multi_held      two or more buttons held
module btn_conditioner #(
    parameter int NBTN         = 7,
    parameter int PRESCALE_W   = 10,
    parameter int STABLE_TICKS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn_raw,
    input  logic            btn_active_high,
    output logic            tick,
    output logic [NBTN-1:0] held,
    output logic [NBTN-1:0] press_pulse,
    output logic [NBTN-1:0] release_pulse,
    output logic            any_held,
    output logic [2:0]      first_idx,
    output logic            multi_held
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_TICKS - 1);

    logic [NBTN-1:0]       btn;
    logic [NBTN-1:0]       s1;
    logic [NBTN-1:0]       s2;
    logic [PRESCALE_W-1:0] prescaler;
    logic [3:0]            cnt [NBTN];

    // Polarity is folded in ahead of the synchroniser, so flipping
    // btn_active_high looks like an ordinary input edge and gets debounced.
    assign btn  = btn_active_high ? btn_raw : ~btn_raw;
    assign tick = (prescaler == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler     <= '0;
            s1            <= '0;
            s2            <= '0;
            held          <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            prescaler     <= prescaler + 1'b1;
            s1            <= btn;
            s2            <= s1;
            press_pulse   <= '0;
            release_pulse <= '0;
            if (tick) begin
                for (int i = 0; i < NBTN; i++) begin
                    // Any tick that sees the held level again drops all progress.
                    if (s2[i] == held[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        held[i]          <= s2[i];
                        press_pulse[i]   <= s2[i];
                        release_pulse[i] <= ~s2[i];
                        cnt[i]           <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    logic [3:0] n_held;

    always_comb begin
        first_idx = 3'd0;
        n_held    = 4'd0;
        // Scan downwards so the lowest-numbered held button wins.
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (held[i]) begin
                first_idx = 3'(i);
            end
            n_held = n_held + {3'd0, held[i]};
        end
        any_held   = |held;
        multi_held = (n_held >= 4'd2);
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner against a cycle-level reference model
module tb_btn_conditioner;

    localparam int NBTN = 7;
    localparam int PW   = 4;
    localparam int ST   = 3;
    localparam int P    = 1 << PW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NBTN-1:0] btn_raw = '0;
    logic            btn_active_high = 1'b1;
    logic            tick;
    logic [NBTN-1:0] held;
    logic [NBTN-1:0] press_pulse;
    logic [NBTN-1:0] release_pulse;
    logic            any_held;
    logic [2:0]      first_idx;
    logic            multi_held;

    btn_conditioner #(.NBTN(NBTN), .PRESCALE_W(PW), .STABLE_TICKS(ST)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_active_high(btn_active_high),
        .tick(tick), .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .any_held(any_held), .first_idx(first_idx), .multi_held(multi_held)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: cycles since reset release define the tick, the
    // pressed level reaches the debouncer two cycles late, and a level flips
    // after ST consecutive ticks that each saw it differ from the held value.
    int              c = 0;
    logic [NBTN-1:0] pipe [2] = '{'0, '0};
    logic [NBTN-1:0] m_held = '0;
    logic [NBTN-1:0] m_press = '0;
    logic [NBTN-1:0] m_rel = '0;
    int              run [NBTN] = '{default: 0};

    always @(posedge clk) begin
        if (!rst_n) begin
            c = 0; pipe[0] = '0; pipe[1] = '0;
            m_held = '0; m_press = '0; m_rel = '0;
            for (int i = 0; i < NBTN; i++) run[i] = 0;
        end else begin
            m_press = '0; m_rel = '0;
            if (c % P == 0) begin
                for (int i = 0; i < NBTN; i++) begin
                    if (pipe[1][i] != m_held[i]) begin
                        run[i] = run[i] + 1;
                        if (run[i] == ST) begin
                            m_held[i] = pipe[1][i];
                            m_press[i] = pipe[1][i];
                            m_rel[i] = !pipe[1][i];
                            run[i] = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
            end
            pipe[1] = pipe[0];
            pipe[0] = btn_active_high ? btn_raw : ~btn_raw;
            c = c + 1;
        end
    end

    function automatic logic [2:0] lowest(input logic [NBTN-1:0] v);
        for (int i = 0; i < NBTN; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("tick",    32'(tick),          32'(c % P == 0));
            check("held",    32'(held),          32'(m_held));
            check("press",   32'(press_pulse),   32'(m_press));
            check("release", 32'(release_pulse), 32'(m_rel));
            check("any",     32'(any_held),      32'(m_held != '0));
            check("first",   32'(first_idx),     32'(lowest(m_held)));
            check("multi",   32'(multi_held),    32'($countones(m_held) >= 2));
        end
    end

    // kind: 0 held rises, 1 held falls, 2 press_pulse, 3 release_pulse.
    // n counts posedges from the change, the first edge that samples it being 1.
    task automatic wait_for(input int kind, input int idx, input int lo, input int hi,
                            input string tag);
        int  n;
        bit  hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            case (kind)
                0: hit = held[idx];
                1: hit = !held[idx];
                2: hit = press_pulse[idx];
                default: hit = release_pulse[idx];
            endcase
        end
        check({tag, "_seen"}, 32'(hit), 32'd1);
        check({tag, "_late_ok"}, 32'(n <= hi), 32'd1);
        check({tag, "_early_ok"}, 32'(n >= lo), 32'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic pol, input logic [NBTN-1:0] raw);
        rst_n = 1'b0;
        btn_active_high = pol;
        btn_raw = raw;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic watch_quiet(input int ch, input int n, input string tag);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (held[ch] || press_pulse[ch]) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_held", 32'(held), 32'd0);
        check("rst_tick", 32'(tick), 32'd1);
        check("rst_pulses", 32'({press_pulse, release_pulse}), 32'd0);
        rst_n = 1'b1;

        // Tick spacing from reset release
        for (int k = 0; k < 3 * P; k++) begin
            check("tick_period", 32'(tick), 32'(k % P == 0));
            @(negedge clk);
        end

        // Single step on button 2
        btn_raw[2] = 1'b1;
        wait_for(0, 2, 35, 51, "step2");
        check("step2_press", 32'(press_pulse), 32'h04);
        check("step2_any", 32'(any_held), 32'd1);
        check("step2_first", 32'(first_idx), 32'd2);
        check("step2_multi", 32'(multi_held), 32'd0);
        cycles(1);
        check("step2_press_once", 32'(press_pulse), 32'd0);
        btn_raw[2] = 1'b0;
        cycles(60);

        // Short glitches on button 0 must not register
        btn_raw[0] = 1'b1;
        cycles(20);
        btn_raw[0] = 1'b0;
        watch_quiet(0, 80, "glitch20");
        for (int k = 0; k < 40; k++) begin
            btn_raw[0] = ~btn_raw[0];
            watch_quiet(0, 5, "toggle5");
        end
        for (int k = 0; k < 20; k++) begin
            btn_raw[0] = ~btn_raw[0];
            cycles(10);
        end
        btn_raw[0] = 1'b0;
        cycles(60);

        // Active-low pins
        do_reset(1'b0, '1);
        cycles(60);
        check("al_idle", 32'(held), 32'd0);
        btn_raw[5] = 1'b0;
        wait_for(0, 5, 35, 51, "al_press");
        check("al_press_pulse", 32'(press_pulse), 32'h20);
        cycles(20);
        btn_raw[5] = 1'b1;
        wait_for(3, 5, 35, 51, "al_rel");
        check("al_rel_held", 32'(held[5]), 32'd0);
        cycles(1);
        check("al_rel_once", 32'(release_pulse), 32'd0);

        // Two buttons together
        do_reset(1'b1, '0);
        cycles(30);
        btn_raw = 7'b0010010;
        wait_for(0, 1, 35, 51, "dual");
        check("dual_held", 32'(held), 32'h12);
        check("dual_press", 32'(press_pulse), 32'h12);
        check("dual_first", 32'(first_idx), 32'd1);
        check("dual_multi", 32'(multi_held), 32'd1);
        btn_raw = '0;
        cycles(60);

        // Reset while pressed, then re-debounce
        btn_raw[3] = 1'b1;
        wait_for(0, 3, 35, 51, "rp_first");
        rst_n = 1'b0;
        cycles(1);
        check("rp_held_cleared", 32'(held), 32'd0);
        check("rp_tick", 32'(tick), 32'd1);
        rst_n = 1'b1;
        wait_for(2, 3, 34, 50, "rp_again");
        btn_raw = '0;
        cycles(60);

        // Random bouncing, occasional polarity flips and resets
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NBTN; i++)
                if ($urandom_range(39, 0) == 0) btn_raw[i] = ~btn_raw[i];
            if ($urandom_range(1499, 0) == 0) btn_active_high = ~btn_active_high;
            rst_n = ($urandom_range(1499, 0) != 0);
            cycles(1);
        end
        rst_n = 1'b1;
        cycles(2);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
